// File: rtl/datapath_arb_pkg.sv
// Shared types for the two-requester datapath arbiter: opcode width, requester id and
// the in-flight tag that follows each issued operation.
package datapath_arb_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef logic req_id_t;

    localparam req_id_t ReqId0 = 1'b0;
    localparam req_id_t ReqId1 = 1'b1;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/datapath_arbiter_if.sv
// Requester-side bundle: operation handshake towards the arbiter and the
// response that comes back from the datapath.
interface datapath_arbiter_if
    import datapath_arb_pkg::*;
#(
    parameter int unsigned N = 16
);
    logic                  valid;
    logic                  ready;
    logic signed [N-1:0]   a;
    logic signed [N-1:0]   b;
    logic [OPCODE_W-1:0]   opcode;
    logic                  rsp_valid;
    logic signed [N-1:0]   rsp_y;
    logic                  rsp_co;

    modport master (
        output valid, a, b, opcode,
        input  ready, rsp_valid, rsp_y, rsp_co
    );

    modport slave (
        input  valid, a, b, opcode,
        output ready, rsp_valid, rsp_y, rsp_co
    );
endinterface

// File: rtl/datapath_tag_pipe.sv
// Shift register of operation tags, one stage per clock, cleared synchronously.
// Reports whether any stage holds a live tag.
module datapath_tag_pipe
    import datapath_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o,
    output logic any_valid_o
);

    tag_t [Depth-1:0] stage_q;
    tag_t [Depth:0]   chain;
    logic [Depth-1:0] valid_vec;

    // chain[0] is the incoming tag, chain[k] is stage k-1.
    assign chain = {stage_q, tag_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= chain[Depth-1:0];
        end
    end

    for (genvar g = 0; g < Depth; g++) begin : g_valid
        assign valid_vec[g] = stage_q[g].valid;
    end

    assign tag_o       = stage_q[Depth-1];
    assign any_valid_o = |valid_vec;

endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter feeding one shared pipelined datapath from two requesters and
// routing each result back to its originator after the datapath latency.
module datapath_arbiter
    import datapath_arb_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned pipe = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    datapath_arbiter_if.slave     req0_if,
    datapath_arbiter_if.slave     req1_if,
    output logic signed [N-1:0]   dp_a_o,
    output logic signed [N-1:0]   dp_b_o,
    output logic [OPCODE_W-1:0]   dp_opcode_o,
    input  logic signed [N-1:0]   dp_y_i,
    input  logic                  dp_co_i,
    output logic                  busy_o
);

    logic                gnt0, gnt1, xfer;
    req_id_t             gnt_id;
    req_id_t             ptr_q, ptr_d;
    tag_t                issue_q, issue_d;
    tag_t                rsp_tag;
    logic                pipe_busy;
    logic signed [N-1:0] dp_a_q, dp_a_d;
    logic signed [N-1:0] dp_b_q, dp_b_d;
    logic [OPCODE_W-1:0] dp_op_q, dp_op_d;

    // The pointer only matters when both requesters are valid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_if.valid && (!req1_if.valid || ptr_q == ReqId0)) begin
                gnt0 = 1'b1;
            end else if (req1_if.valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign xfer   = gnt0 | gnt1;
    assign gnt_id = gnt1 ? ReqId1 : ReqId0;

    always_comb begin
        ptr_d   = ptr_q;
        dp_a_d  = dp_a_q;
        dp_b_d  = dp_b_q;
        dp_op_d = dp_op_q;
        issue_d = '{valid: xfer, id: gnt_id};
        if (xfer) begin
            ptr_d   = other_id(gnt_id);
            dp_a_d  = gnt1 ? req1_if.a      : req0_if.a;
            dp_b_d  = gnt1 ? req1_if.b      : req0_if.b;
            dp_op_d = gnt1 ? req1_if.opcode : req0_if.opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= ReqId0;
            issue_q <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            dp_op_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            issue_q <= issue_d;
            dp_a_q  <= dp_a_d;
            dp_b_q  <= dp_b_d;
            dp_op_q <= dp_op_d;
        end
    end

    // issue_q aligns with the datapath input register, so the tag pipe adds exactly pipe.
    datapath_tag_pipe #(
        .Depth (pipe)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .tag_i       (issue_q),
        .tag_o       (rsp_tag),
        .any_valid_o (pipe_busy)
    );

    assign dp_a_o      = dp_a_q;
    assign dp_b_o      = dp_b_q;
    assign dp_opcode_o = dp_op_q;

    assign req0_if.ready = gnt0;
    assign req1_if.ready = gnt1;

    assign req0_if.rsp_valid = !rst && rsp_tag.valid && (rsp_tag.id == ReqId0);
    assign req1_if.rsp_valid = !rst && rsp_tag.valid && (rsp_tag.id == ReqId1);
    assign req0_if.rsp_y     = dp_y_i;
    assign req1_if.rsp_y     = dp_y_i;
    assign req0_if.rsp_co    = dp_co_i;
    assign req1_if.rsp_co    = dp_co_i;

    assign busy_o = !rst && (issue_q.valid || pipe_busy);

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter with a two-stage adder standing in for the datapath.
module tb_datapath_arbiter;
    import datapath_arb_pkg::*;

    localparam int unsigned N    = 16;
    localparam int unsigned PIPE = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [N-1:0] dp_a, dp_b, dp_y;
    logic [OPCODE_W-1:0] dp_opcode;
    logic                dp_co;
    logic                busy;

    int checks = 0;
    int errors = 0;

    datapath_arbiter_if #(.N(N)) r0 ();
    datapath_arbiter_if #(.N(N)) r1 ();

    datapath_arbiter #(
        .N    (N),
        .pipe (PIPE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_if     (r0),
        .req1_if     (r1),
        .dp_a_o      (dp_a),
        .dp_b_o      (dp_b),
        .dp_opcode_o (dp_opcode),
        .dp_y_i      (dp_y),
        .dp_co_i     (dp_co),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: opcode 000 adds, anything else passes A; two register stages.
    logic [N:0] dp_sum;
    logic [N:0] s1_q = '0;
    logic [N:0] s2_q = '0;
    always_comb begin
        dp_sum = {1'b0, dp_a};
        if (dp_opcode == 3'b000) dp_sum = {1'b0, dp_a} + {1'b0, dp_b};
    end
    always_ff @(posedge clk) begin
        s1_q <= dp_sum;
        s2_q <= s1_q;
    end
    assign dp_y  = s2_q[N-1:0];
    assign dp_co = s2_q[N];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op);
        r0.valid = v; r0.a = a; r0.b = b; r0.opcode = op;
    endtask

    task automatic set1(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op);
        r1.valid = v; r1.a = a; r1.b = b; r1.opcode = op;
    endtask

    initial begin
        rst = 1'b1;
        set0(1'b1, 16'd0, 16'd0, 3'b000);
        set1(1'b1, 16'd0, 16'd0, 3'b000);
        #2;
        chk("rst_ready0", 16'(r0.ready), 16'd0);
        chk("rst_ready1", 16'(r1.ready), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        tick();
        tick();
        chk("rst_dp_a", dp_a, 16'd0);
        chk("rst_dp_b", dp_b, 16'd0);
        chk("rst_dp_op", 16'(dp_opcode), 16'd0);
        chk("rst_rsp0", 16'(r0.rsp_valid), 16'd0);
        chk("rst_rsp1", 16'(r1.rsp_valid), 16'd0);
        set0(1'b0, 16'd0, 16'd0, 3'b000);
        set1(1'b0, 16'd0, 16'd0, 3'b000);
        rst = 1'b0;
        tick();
        chk("idle_busy", 16'(busy), 16'd0);

        // Single add from requester 0: 5 + 3.
        set0(1'b1, 16'd5, 16'd3, 3'b000);
        #1;
        chk("add_ready0", 16'(r0.ready), 16'd1);
        chk("add_ready1", 16'(r1.ready), 16'd0);
        tick();
        set0(1'b0, 16'd0, 16'd0, 3'b000);
        chk("add_dp_a", dp_a, 16'd5);
        chk("add_dp_b", dp_b, 16'd3);
        chk("add_busy_k", 16'(busy), 16'd1);
        chk("add_rsp0_k", 16'(r0.rsp_valid), 16'd0);
        tick();
        chk("add_rsp0_k1", 16'(r0.rsp_valid), 16'd0);
        tick();
        chk("add_rsp0_k2", 16'(r0.rsp_valid), 16'd1);
        chk("add_y", r0.rsp_y, 16'd8);
        chk("add_rsp1_k2", 16'(r1.rsp_valid), 16'd0);
        tick();
        chk("add_rsp0_k3", 16'(r0.rsp_valid), 16'd0);
        chk("add_busy_k3", 16'(busy), 16'd0);

        // Round-robin from reset: both valid for four cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1'b1, 16'd10, 16'd1, 3'b000);
        set1(1'b1, 16'd20, 16'd2, 3'b000);
        #1;
        chk("rr_c0_ready0", 16'(r0.ready), 16'd1);
        chk("rr_c0_ready1", 16'(r1.ready), 16'd0);
        tick();
        chk("rr_e0_rsp0", 16'(r0.rsp_valid), 16'd0);
        chk("rr_c1_ready0", 16'(r0.ready), 16'd0);
        chk("rr_c1_ready1", 16'(r1.ready), 16'd1);
        tick();
        chk("rr_e1_rsp1", 16'(r1.rsp_valid), 16'd0);
        chk("rr_c2_ready0", 16'(r0.ready), 16'd1);
        chk("rr_c2_ready1", 16'(r1.ready), 16'd0);
        tick();
        chk("rr_e2_rsp0", 16'(r0.rsp_valid), 16'd1);
        chk("rr_e2_y", r0.rsp_y, 16'd11);
        chk("rr_e2_rsp1", 16'(r1.rsp_valid), 16'd0);
        chk("rr_c3_ready1", 16'(r1.ready), 16'd1);
        tick();
        set0(1'b0, 16'd0, 16'd0, 3'b000);
        set1(1'b0, 16'd0, 16'd0, 3'b000);
        chk("rr_e3_rsp1", 16'(r1.rsp_valid), 16'd1);
        chk("rr_e3_y", r1.rsp_y, 16'd22);
        chk("rr_e3_rsp0", 16'(r0.rsp_valid), 16'd0);
        tick();
        chk("rr_e4_rsp0", 16'(r0.rsp_valid), 16'd1);
        chk("rr_e4_y", r0.rsp_y, 16'd11);
        tick();
        chk("rr_e5_rsp1", 16'(r1.rsp_valid), 16'd1);
        chk("rr_e5_rsp0", 16'(r0.rsp_valid), 16'd0);
        tick();
        chk("rr_e6_busy", 16'(busy), 16'd0);

        // Signed overflow on requester 1: 32767 + 1.
        set1(1'b1, 16'h7fff, 16'd1, 3'b000);
        #1;
        chk("ovf_ready1", 16'(r1.ready), 16'd1);
        tick();
        set1(1'b0, 16'd0, 16'd0, 3'b000);
        tick();
        tick();
        chk("ovf_rsp1", 16'(r1.rsp_valid), 16'd1);
        chk("ovf_y", r1.rsp_y, 16'h8000);
        chk("ovf_co", 16'(r1.rsp_co), 16'd0);
        chk("ovf_rsp0", 16'(r0.rsp_valid), 16'd0);
        tick();

        // Reset one cycle after an issue discards the operation.
        set0(1'b1, 16'd1, 16'd1, 3'b110);
        tick();
        chk("rstmid_dp_op", 16'(dp_opcode), 16'd6);
        rst = 1'b1;
        #1;
        chk("rstmid_ready0", 16'(r0.ready), 16'd0);
        chk("rstmid_busy_in", 16'(busy), 16'd0);
        tick();
        rst = 1'b0;
        set0(1'b0, 16'd0, 16'd0, 3'b000);
        #1;
        chk("rstmid_busy", 16'(busy), 16'd0);
        chk("rstmid_rsp0_a", 16'(r0.rsp_valid), 16'd0);
        tick();
        chk("rstmid_rsp0_b", 16'(r0.rsp_valid), 16'd0);
        chk("rstmid_rsp1_b", 16'(r1.rsp_valid), 16'd0);
        tick();
        chk("rstmid_rsp0_c", 16'(r0.rsp_valid), 16'd0);
        set0(1'b1, 16'd0, 16'd0, 3'b000);
        set1(1'b1, 16'd0, 16'd0, 3'b000);
        #1;
        chk("rstmid_ptr0", 16'(r0.ready), 16'd1);
        chk("rstmid_ptr1", 16'(r1.ready), 16'd0);
        set0(1'b0, 16'd0, 16'd0, 3'b000);
        set1(1'b0, 16'd0, 16'd0, 3'b000);
        tick();

        // Requester 0 alone for three cycles.
        chk("burst_busy_pre", 16'(busy), 16'd0);
        set0(1'b1, 16'd1, 16'd100, 3'b000);
        #1;
        chk("burst_ready_a", 16'(r0.ready), 16'd1);
        tick();
        chk("burst_busy_e0", 16'(busy), 16'd1);
        set0(1'b1, 16'd2, 16'd100, 3'b000);
        #1;
        chk("burst_ready_b", 16'(r0.ready), 16'd1);
        tick();
        chk("burst_busy_e1", 16'(busy), 16'd1);
        set0(1'b1, 16'd3, 16'd100, 3'b000);
        #1;
        chk("burst_ready_c", 16'(r0.ready), 16'd1);
        tick();
        set0(1'b0, 16'd0, 16'd0, 3'b000);
        chk("burst_busy_e2", 16'(busy), 16'd1);
        chk("burst_rsp_e2", 16'(r0.rsp_valid), 16'd1);
        chk("burst_y_e2", r0.rsp_y, 16'd101);
        tick();
        chk("burst_busy_e3", 16'(busy), 16'd1);
        chk("burst_rsp_e3", 16'(r0.rsp_valid), 16'd1);
        chk("burst_y_e3", r0.rsp_y, 16'd102);
        tick();
        chk("burst_busy_e4", 16'(busy), 16'd1);
        chk("burst_rsp_e4", 16'(r0.rsp_valid), 16'd1);
        chk("burst_y_e4", r0.rsp_y, 16'd103);
        chk("burst_rsp1_e4", 16'(r1.rsp_valid), 16'd0);
        tick();
        chk("burst_busy_e5", 16'(busy), 16'd0);
        chk("burst_rsp_e5", 16'(r0.rsp_valid), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter N, 16, operand/result width in bits (equal to the datapath's N).
REQ-002 Parameter pipe, 2, datapath latency in clock edges (pipe >= 1, equal to the datapath's pipe).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 reqX_valid  input  1  requester X (X = 0, 1) has an operation pending.
REQ-006 reqX_ready  output  1  arbiter accepts requester X's operation this cycle.
REQ-007 reqX_a, reqX_b  input  N (signed)  requester X operands.
REQ-008 reqX_opcode  input  3  requester X datapath opcode.
REQ-009 dp_a, dp_b  output  N (signed)  registered operands to the datapath.
REQ-010 dp_opcode  output  3  registered opcode to the datapath.
REQ-011 dp_y  input  N (signed)  datapath result Y.
REQ-012 dp_co  input  1  datapath carry-out co.
REQ-013 rspX_valid  output  1  result for requester X is present this cycle.
REQ-014 rspX_y, rspX_co  output  N / 1  result and carry routed to requester X.
REQ-015 busy  output  1  at least one operation is in flight.

Function
REQ-016 Transfer occurs on a posedge where reqX_valid && reqX_ready; at most one transfer per cycle.
REQ-017 reqX_ready is combinational: it is asserted only for the granted requester, only while that requester's valid is high and rst is low.
REQ-018 Arbitration is round-robin: a single priority pointer favours one requester; only one valid means that one is granted; both valid means the pointer's favoured requester is granted.
REQ-019 After each transfer, the pointer moves to the non-granted requester; with no transfer, the pointer holds.
REQ-020 Issue: on a transfer edge k, dp_a, dp_b and dp_opcode load the granted operands; with no transfer they hold their previous values.
REQ-021 A tag (valid bit and requester id) is loaded with every issue and shifts each edge through a tag pipeline of total latency pipe.
REQ-022 An operation issued at edge k has rspX_valid = 1 for exactly one cycle, between edges k+pipe and k+pipe+1, for its own requester only.
REQ-023 rspX_y and rspX_co pass dp_y and dp_co through combinationally; their values are don't-care while rspX_valid = 0.
REQ-024 Throughput is one issue per cycle; back-to-back issues yield back-to-back responses in issue order.
REQ-025 Responses have no backpressure: a requester must accept a response in the cycle it is presented.
REQ-026 busy = OR of all in-flight tag valid bits, including the tag of an operation issued at the current edge.
REQ-027 A requester that drops valid without a transfer loses nothing; the arbiter keeps no per-requester queue.

Reset
REQ-028 While rst = 1 at a posedge: pointer = 0 (requester 0 favoured), all tag valid bits = 0, dp_a = 0, dp_b = 0, dp_opcode = 000.
REQ-029 While rst = 1: req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0, busy = 0.
REQ-030 Reset mid-operation discards all in-flight tags; no response is ever emitted for an operation issued before reset.

Structure
REQ-031 Package datapath_arb_pkg holds OPCODE_W = 3, the requester-id type (1 bit), and the tag struct {valid, id}.
REQ-032 Sub-module datapath_tag_pipe, parameterised by depth, implements the tag shift register with synchronous clear.
REQ-033 The datapath instance lives outside this block; the bench instantiates both.

Verification (datapath configured with N = 16, pipe = 2, opcode 000 = add)
REQ-034 Only req0 valid, A = 5, B = 3, op = 000 issued at edge k -> dp_a = 5 and dp_b = 3 after edge k; rsp0_valid after edge k+2 with rsp0_y = 8; rsp1_valid stays 0.
REQ-035 Both requesters valid continuously for 4 cycles after reset -> grants alternate 0, 1, 0, 1; responses alternate with the same ids, 2 cycles delayed.
REQ-036 Signed overflow, req1 issues A = 32767, B = 1 -> rsp1_y = -32768 with co reported as the datapath drives it, routed only to requester 1.
REQ-037 Reset asserted 1 cycle after an issue -> no rspX_valid ever appears for that operation; busy = 0 after the reset edge; pointer returns to requester 0.
REQ-038 req1 idle, req0 valid for 3 consecutive cycles -> 3 consecutive grants to req0, 3 consecutive rsp0 pulses, busy high for exactly 5 cycles.
